// File: rtl/add8_sequencer.sv
// Runs one 8-bit add or subtract as two passes through a 4-bit nibble adder:
// the low nibble first, then the high nibble. Returns the result and flags to
// the ALU controller through a start/done handshake.
module add8_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       sub,
    output logic [7:0] result,
    output logic       c_out,
    output logic       overflow,
    output logic       zero,
    output logic       error,
    output logic       busy,
    output logic       done,
    output logic       add_en,
    output logic [3:0] add_A,
    output logic [3:0] add_B,
    output logic       add_c_in,
    input  logic [3:0] add_sum,
    input  logic       add_c_out,
    input  logic       add_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        GAP,
        HIGH,
        DONE
    } state_t;

    state_t        state_reg;
    logic [7:0]    a_reg;
    logic [7:0]    bop_reg;
    logic [3:0]    low_reg;
    logic          c_mid_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            bop_reg   <= '0;
            low_reg   <= '0;
            c_mid_reg <= 1'b0;
            count_reg <= '0;
            result    <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            add_en    <= 1'b0;
            add_A     <= '0;
            add_B     <= '0;
            add_c_in  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    state_reg <= IDLE;
                    // DONE behaves as idle for acceptance so a back-to-back
                    // start lands on the edge right after the done pulse.
                    if (start) begin
                        a_reg     <= A;
                        bop_reg   <= sub ? ~B : B;
                        add_A     <= A[3:0];
                        add_B     <= sub ? ~B[3:0] : B[3:0];
                        add_c_in  <= sub;
                        add_en    <= 1'b1;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        count_reg <= '0;
                        state_reg <= LOW;
                    end
                end

                LOW: begin
                    if (add_ready) begin
                        low_reg   <= add_sum;
                        c_mid_reg <= add_c_out;
                        add_en    <= 1'b0;
                        state_reg <= GAP;
                    end else if (count_reg == CW'(TIMEOUT - 1)) begin
                        result    <= '0;
                        c_out     <= 1'b0;
                        overflow  <= 1'b0;
                        zero      <= 1'b0;
                        error     <= 1'b1;
                        add_en    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end

                GAP: begin
                    // Wait for ready to drop so the adder's enable count restarts.
                    if (!add_ready) begin
                        add_A     <= a_reg[7:4];
                        add_B     <= bop_reg[7:4];
                        add_c_in  <= c_mid_reg;
                        add_en    <= 1'b1;
                        count_reg <= '0;
                        state_reg <= HIGH;
                    end
                end

                HIGH: begin
                    if (add_ready) begin
                        result    <= {add_sum, low_reg};
                        c_out     <= add_c_out;
                        overflow  <= (a_reg[7] == bop_reg[7]) && (add_sum[3] != a_reg[7]);
                        zero      <= ({add_sum, low_reg} == 8'h00);
                        add_en    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else if (count_reg == CW'(TIMEOUT - 1)) begin
                        result    <= '0;
                        c_out     <= 1'b0;
                        overflow  <= 1'b0;
                        zero      <= 1'b0;
                        error     <= 1'b1;
                        add_en    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end

                default: begin
                    add_en    <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
